// File: rtl/data_mem_ctrl_pkg.sv
// Shared encodings for the data-memory access controller.
package data_mem_ctrl_pkg;

  localparam logic [1:0] MEM_SIZE_BYTE = 2'd0;
  localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
  localparam logic [1:0] MEM_SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    DMC_IDLE = 2'd0,
    DMC_REQ  = 2'd1,
    DMC_DONE = 2'd2
  } dmc_state_e;

  // Halfwords need an even address, words a multiple of four; size 3 behaves as word.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      MEM_SIZE_BYTE: return 1'b0;
      MEM_SIZE_HALF: return addr_lo[0];
      default:       return (addr_lo != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Handshaked single-port memory bus between the controller and memory.
interface data_mem_ctrl_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/data_mem_ctrl_lane_align.sv
// Byte-lane steering: store enables/replication and load extraction.
module data_mem_ctrl_lane_align
  import data_mem_ctrl_pkg::*;
(
  input  logic [1:0]  i_addr_lo,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_dout,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata_ext
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Pick the addressed lane, then build enables, replicated store data and the extended load.
  always_comb begin
    case (i_addr_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    case (i_size)
      MEM_SIZE_BYTE: begin
        o_be        = 4'b0001 << i_addr_lo;
        o_wdata     = {4{i_dout[7:0]}};
        o_rdata_ext = {{24{~i_unsigned & w_byte[7]}}, w_byte};
      end
      MEM_SIZE_HALF: begin
        o_be        = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata     = {2{i_dout[15:0]}};
        o_rdata_ext = {{16{~i_unsigned & w_half[15]}}, w_half};
      end
      default: begin
        o_be        = 4'b1111;
        o_wdata     = i_dout;
        o_rdata_ext = i_rdata;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// MEM-stage data-memory controller: request latch, bus FSM, timeout and load result.
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_mem_ren,
  input  logic               i_mem_wen,
  input  logic [31:0]        i_mem_addr,
  input  logic [31:0]        i_mem_dout,
  input  logic [1:0]         i_mem_size,
  input  logic               i_mem_unsigned,
  output logic [31:0]        o_mem_din,
  output logic               o_mem_stall,
  output logic               o_mem_addr_err,
  output logic               o_bus_err,
  data_mem_ctrl_if.master    bus
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  dmc_state_e  r_state, w_state_nxt;
  logic [7:0]  r_cnt;
  logic        r_bus_req, r_bus_we, r_bus_err;
  logic [31:0] r_bus_addr, r_bus_wdata, r_mem_din;
  logic [3:0]  r_bus_be;
  logic [1:0]  r_size, r_addr_lo;
  logic        r_unsigned;

  logic        w_req, w_mis, w_accept, w_ack, w_timeout;
  logic [1:0]  w_sel_size, w_sel_addr_lo;
  logic        w_sel_unsigned;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_rdata_ext;

  assign w_req = i_mem_ren | i_mem_wen;
  assign w_mis = is_misaligned(i_mem_size, i_mem_addr[1:0]);

  // The aligner sees the live request while idle and the latched one during the bus access.
  assign w_sel_size     = (r_state == DMC_IDLE) ? i_mem_size       : r_size;
  assign w_sel_addr_lo  = (r_state == DMC_IDLE) ? i_mem_addr[1:0]  : r_addr_lo;
  assign w_sel_unsigned = (r_state == DMC_IDLE) ? i_mem_unsigned   : r_unsigned;

  data_mem_ctrl_lane_align u_lane_align (
    .i_addr_lo   (w_sel_addr_lo),
    .i_size      (w_sel_size),
    .i_unsigned  (w_sel_unsigned),
    .i_dout      (i_mem_dout),
    .i_rdata     (bus.bus_rdata),
    .o_be        (w_be),
    .o_wdata     (w_wdata),
    .o_rdata_ext (w_rdata_ext)
  );

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= DMC_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state and combinational stall / misalignment flags.
  always_comb begin
    w_state_nxt    = r_state;
    o_mem_stall    = 1'b0;
    o_mem_addr_err = 1'b0;
    w_accept       = 1'b0;
    w_ack          = 1'b0;
    w_timeout      = 1'b0;
    case (r_state)
      DMC_IDLE: begin
        if (w_req) begin
          if (w_mis) begin
            o_mem_addr_err = 1'b1;
          end else begin
            w_accept    = 1'b1;
            o_mem_stall = 1'b1;
            w_state_nxt = DMC_REQ;
          end
        end
      end
      DMC_REQ: begin
        o_mem_stall = 1'b1;
        if (bus.bus_ack && r_bus_req) begin
          w_ack       = 1'b1;
          w_state_nxt = DMC_DONE;
        end else if (r_cnt == CNT_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = DMC_DONE;
        end
      end
      DMC_DONE: w_state_nxt = DMC_IDLE;
      default:  w_state_nxt = DMC_IDLE;
    endcase
  end

  // Request latch, bus outputs, timeout counter and load result.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt       <= 8'd0;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_err   <= 1'b0;
      r_bus_addr  <= 32'd0;
      r_bus_wdata <= 32'd0;
      r_bus_be    <= 4'd0;
      r_mem_din   <= 32'd0;
      r_size      <= 2'd0;
      r_addr_lo   <= 2'd0;
      r_unsigned  <= 1'b0;
    end else begin
      r_bus_err <= 1'b0;
      if (w_accept) begin
        r_cnt       <= 8'd0;
        r_bus_req   <= 1'b1;
        r_bus_we    <= i_mem_wen;
        r_bus_addr  <= {i_mem_addr[31:2], 2'b00};
        r_bus_be    <= w_be;
        r_bus_wdata <= w_wdata;
        r_size      <= i_mem_size;
        r_addr_lo   <= i_mem_addr[1:0];
        r_unsigned  <= i_mem_unsigned;
      end else if (w_ack) begin
        r_bus_req <= 1'b0;
        if (!r_bus_we) r_mem_din <= w_rdata_ext;
      end else if (w_timeout) begin
        r_bus_req <= 1'b0;
        r_bus_err <= 1'b1;
        if (!r_bus_we) r_mem_din <= ERR_DATA;
      end else if (r_state == DMC_REQ) begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  assign o_mem_din     = r_mem_din;
  assign o_bus_err     = r_bus_err;
  assign bus.bus_req   = r_bus_req;
  assign bus.bus_we    = r_bus_we;
  assign bus.bus_addr  = r_bus_addr;
  assign bus.bus_be    = r_bus_be;
  assign bus.bus_wdata = r_bus_wdata;

endmodule
